slug_port_bank: RTL and testbench

SLUG_PORT_BANK -- requirements
Module: slug_port_bank

---
 rtl/slug_pkg.sv | 16 +
 rtl/slug_port_chan.sv | 88 ++++++++
 rtl/slug_port_bank.sv | 81 ++++++++
 tb/tb_slug_port_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/slug_pkg.sv
// rtl/slug_pkg.sv - shared status bit layout and per-channel flag bundle for the slug port bank
package slug_pkg;

    // Bit positions inside the status word returned by a status read.
    localparam int ST_IN_FULL   = 0;
    localparam int ST_OUT_VALID = 1;
    localparam int ST_OVERRUN   = 2;

    // Flags a channel exports to the top-level read mux.
    typedef struct packed {
        logic overrun;
        logic out_valid;
        logic in_full;
    } chan_flags_t;

endpackage

// File: rtl/slug_port_chan.sv
// rtl/slug_port_chan.sv - one input holding register plus one output register with overrun tracking
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_data, rd_stat, wr_en  CPU strobes already decoded for this channel
//   wdata                    CPU write data
//   in_data/in_valid/in_ready     input side handshake
//   out_data/out_valid/out_ready  output side handshake
//   hold                     holding register contents (for data reads)
//   flags                    in_full / out_valid / overrun (for status reads)
module slug_port_chan
    import slug_pkg::*;
#(
    parameter int NIBBLE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_data,
    input  logic                rd_stat,
    input  logic                wr_en,
    input  logic [NIBBLE_W-1:0] wdata,
    input  logic [NIBBLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NIBBLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NIBBLE_W-1:0] hold,
    output chan_flags_t         flags
);

    logic in_full;
    logic rst_q;
    logic overrun;
    logic in_beat;
    logic out_load;
    logic wr_drop;

    assign in_beat  = in_valid & ~in_full;
    // A write lands when the register is free or is being emptied this cycle.
    assign out_load = wr_en & (~out_valid | out_ready);
    assign wr_drop  = wr_en & out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            // in_full is held high during reset so in_ready stays low until
            // the first edge after reset is released.
            in_full   <= 1'b1;
            rst_q     <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rst_q <= 1'b0;
            if (rst_q) begin
                in_full <= 1'b0;
            end else if (in_beat) begin
                hold    <= in_data;
                in_full <= 1'b1;
            end else if (rd_data) begin
                in_full <= 1'b0;
            end

            if (out_load) begin
                out_data  <= wdata;
                out_valid <= 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end

            // A new drop wins over a simultaneous status-read clear.
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (rd_stat) begin
                overrun <= 1'b0;
            end
        end
    end

    assign in_ready = ~in_full;

    // The forced reset value of in_full is not a real full condition.
    assign flags.in_full   = in_full & ~rst_q;
    assign flags.out_valid = out_valid;
    assign flags.overrun   = overrun;

endmodule

// File: rtl/slug_port_bank.sv
// rtl/slug_port_bank.sv - bank of CHANNELS input/output nibble ports behind a CPU select/read/write interface
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sel, rd, stat, wr   CPU access: channel select, read strobe, status qualifier, write strobe
//   wdata, rdata        CPU write / read data; rdata_oe high while rd is asserted
//   in_data/in_valid/in_ready     packed per-channel input streams
//   out_data/out_valid/out_ready  packed per-channel output streams
module slug_port_bank
    import slug_pkg::*;
#(
    parameter int NIBBLE_W = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         rd,
    input  logic                         stat,
    input  logic                         wr,
    input  logic [NIBBLE_W-1:0]          wdata,
    output logic [NIBBLE_W-1:0]          rdata,
    output logic                         rdata_oe,
    input  logic [CHANNELS*NIBBLE_W-1:0] in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    output logic [CHANNELS*NIBBLE_W-1:0] out_data,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready
);

    logic [CHANNELS-1:0] sel_hit;
    logic [NIBBLE_W-1:0] hold  [CHANNELS];
    chan_flags_t         flags [CHANNELS];

    // A select value beyond the last channel matches no channel, so such
    // accesses read 0 and touch no state.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign sel_hit[i] = (sel == SEL_W'(i));

        slug_port_chan #(
            .NIBBLE_W (NIBBLE_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .rd_data   (rd & ~stat & sel_hit[i]),
            .rd_stat   (rd & stat & sel_hit[i]),
            .wr_en     (wr & sel_hit[i]),
            .wdata     (wdata),
            .in_data   (in_data[i*NIBBLE_W +: NIBBLE_W]),
            .in_valid  (in_valid[i]),
            .in_ready  (in_ready[i]),
            .out_data  (out_data[i*NIBBLE_W +: NIBBLE_W]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .hold      (hold[i]),
            .flags     (flags[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_hit[i]) begin
                    if (stat) begin
                        rdata[ST_IN_FULL]   = flags[i].in_full;
                        rdata[ST_OUT_VALID] = flags[i].out_valid;
                        rdata[ST_OVERRUN]   = flags[i].overrun;
                    end else begin
                        rdata = hold[i];
                    end
                end
            end
        end
    end

    assign rdata_oe = rd;

endmodule

// File: tb/tb_slug_port_bank.sv
// tb/tb_slug_port_bank.sv - table-driven and sequence checks for slug_port_bank
module tb_slug_port_bank;

    localparam int NW = 4;
    localparam int CH = 6;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic            rd = 1'b0;
    logic            stat = 1'b0;
    logic            wr = 1'b0;
    logic [NW-1:0]   wdata = '0;
    logic [NW-1:0]   rdata;
    logic            rdata_oe;
    logic [CH*NW-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic [CH-1:0]   in_ready;
    logic [CH*NW-1:0] out_data;
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_ready = '0;

    int tests = 0;
    int failed = 0;

    slug_port_bank #(
        .NIBBLE_W (NW),
        .CHANNELS (CH),
        .SEL_W    (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .rd        (rd),
        .stat      (stat),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rdata_oe  (rdata_oe),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0]    sel;
        logic             rd;
        logic             stat;
        logic             wr;
        logic [NW-1:0]    wdata;
        logic [CH-1:0]    in_valid;
        logic [CH*NW-1:0] in_data;
        logic [CH-1:0]    out_ready;
        logic [NW-1:0]    exp_rdata;
        logic [CH-1:0]    exp_in_ready;
        logic [CH-1:0]    exp_out_valid;
        logic [CH*NW-1:0] exp_out_data;
    } vec_t;

    vec_t vecs[20];
    logic [NW-1:0] vals[8];

    function automatic vec_t mk(
        input logic [SW-1:0] s, input logic r, input logic st, input logic w,
        input logic [NW-1:0] wd, input logic [CH-1:0] iv, input logic [CH*NW-1:0] id,
        input logic [CH-1:0] ordy, input logic [NW-1:0] erd, input logic [CH-1:0] eir,
        input logic [CH-1:0] eov, input logic [CH*NW-1:0] eod);
        vec_t v;
        v.sel = s; v.rd = r; v.stat = st; v.wr = w; v.wdata = wd;
        v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
        v.exp_rdata = erd; v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_out_data = eod;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sidx;
        int ridx;
        logic beat;

        //        sel rd st wr wd     in_valid in_data      ordy    rdata  in_rdy  o_valid o_data
        vecs[0]  = mk(0, 0, 0, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h00, 24'h000000);
        vecs[1]  = mk(0, 0, 0, 0, 4'h0, 6'h04, 24'h000A00, 6'h00, 4'h0, 6'h3B, 6'h00, 24'h000000);
        vecs[2]  = mk(2, 1, 1, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'h1, 6'h3B, 6'h00, 24'h000000);
        vecs[3]  = mk(2, 1, 0, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'hA, 6'h3F, 6'h00, 24'h000000);
        vecs[4]  = mk(2, 1, 0, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'hA, 6'h3F, 6'h00, 24'h000000);
        vecs[5]  = mk(5, 0, 0, 1, 4'h3, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h20, 24'h300000);
        vecs[6]  = mk(5, 0, 0, 1, 4'h7, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h20, 24'h300000);
        vecs[7]  = mk(5, 1, 1, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'h6, 6'h3F, 6'h20, 24'h300000);
        vecs[8]  = mk(5, 1, 1, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'h2, 6'h3F, 6'h20, 24'h300000);
        vecs[9]  = mk(1, 0, 0, 1, 4'h5, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h22, 24'h300050);
        vecs[10] = mk(1, 0, 0, 1, 4'h9, 6'h00, 24'h000000, 6'h02, 4'h0, 6'h3F, 6'h22, 24'h300090);
        vecs[11] = mk(1, 0, 0, 0, 4'h0, 6'h00, 24'h000000, 6'h02, 4'h0, 6'h3F, 6'h20, 24'h300090);
        vecs[12] = mk(1, 1, 1, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h20, 24'h300090);
        vecs[13] = mk(5, 0, 0, 1, 4'h1, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h20, 24'h300090);
        vecs[14] = mk(6, 1, 0, 1, 4'hF, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h20, 24'h300090);
        vecs[15] = mk(7, 1, 1, 1, 4'hF, 6'h00, 24'h000000, 6'h00, 4'h0, 6'h3F, 6'h20, 24'h300090);
        vecs[16] = mk(5, 1, 1, 0, 4'h0, 6'h00, 24'h000000, 6'h00, 4'h6, 6'h3F, 6'h20, 24'h300090);
        vecs[17] = mk(0, 0, 0, 0, 4'h0, 6'h08, 24'h00C000, 6'h00, 4'h0, 6'h37, 6'h20, 24'h300090);
        vecs[18] = mk(3, 1, 0, 1, 4'h4, 6'h00, 24'h000000, 6'h00, 4'hC, 6'h3F, 6'h28, 24'h304090);
        vecs[19] = mk(0, 0, 0, 0, 4'h0, 6'h00, 24'h000000, 6'h3F, 4'h0, 6'h3F, 6'h00, 24'h304090);

        for (int k = 0; k < 8; k++) vals[k] = NW'((k * 5 + 1) % 16);

        // Power-up reset: in_ready stays low while rst is held.
        rst = 1'b1;
        tick();
        tick();
        check("rst in_ready held low", 32'(in_ready), 32'h0);
        check("rst out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        tick();
        check("post-rst in_ready", 32'(in_ready), 32'h3F);
        check("post-rst out_data", 32'(out_data), 32'h0);
        check("post-rst rdata idle", 32'(rdata), 32'h0);

        for (int k = 0; k < 20; k++) begin
            sel = vecs[k].sel; rd = vecs[k].rd; stat = vecs[k].stat; wr = vecs[k].wr;
            wdata = vecs[k].wdata; in_valid = vecs[k].in_valid; in_data = vecs[k].in_data;
            out_ready = vecs[k].out_ready;
            #1;
            check($sformatf("v%0d rdata", k), 32'(rdata), 32'(vecs[k].exp_rdata));
            check($sformatf("v%0d rdata_oe", k), 32'(rdata_oe), 32'(vecs[k].rd));
            tick();
            check($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].exp_in_ready));
            check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_out_valid));
            check($sformatf("v%0d out_data", k), 32'(out_data), 32'(vecs[k].exp_out_data));
        end
        rd = 1'b0; wr = 1'b0; stat = 1'b0; out_ready = '0; in_valid = '0; in_data = '0;

        // Fill every channel, then pulse reset with transfers and strobes pending.
        in_valid = 6'h3F; in_data = 24'h654321;
        sel = 0; wr = 1'b1; wdata = 4'hE;
        tick();
        check("fill in_ready", 32'(in_ready), 32'h0);
        check("fill out_valid", 32'(out_valid), 32'h01);
        rst = 1'b1; sel = 2; wr = 1'b1; rd = 1'b1; stat = 1'b0;
        tick();
        check("rst pulse in_ready", 32'(in_ready), 32'h0);
        check("rst pulse out_valid", 32'(out_valid), 32'h0);
        check("rst pulse out_data", 32'(out_data), 32'h0);
        rst = 1'b0; in_valid = '0; wr = 1'b0; rd = 1'b0;
        tick();
        check("rst release in_ready", 32'(in_ready), 32'h3F);
        check("rst release out_valid", 32'(out_valid), 32'h0);
        for (int c = 0; c < CH; c++) begin
            sel = SW'(c); rd = 1'b1; stat = 1'b0;
            #1;
            check($sformatf("rst hold ch%0d", c), 32'(rdata), 32'h0);
            stat = 1'b1;
            #1;
            check($sformatf("rst status ch%0d", c), 32'(rdata), 32'h0);
        end
        rd = 1'b0; stat = 1'b0;
        tick();

        // Streaming on ch0 with a data read every other cycle.
        sidx = 0;
        ridx = 0;
        sel = 0;
        for (int cyc = 0; cyc < 100 && ridx < 8; cyc++) begin
            in_valid = (sidx < 8) ? 6'h01 : 6'h00;
            in_data = (sidx < 8) ? {20'h0, vals[sidx]} : 24'h0;
            rd = ((cyc % 2) == 1) && !in_ready[0];
            #1;
            if (rd) begin
                check($sformatf("stream value %0d", ridx), 32'(rdata), 32'(vals[ridx]));
                ridx++;
            end
            beat = in_valid[0] && in_ready[0];
            tick();
            if (beat) sidx++;
        end
        rd = 1'b0; in_valid = '0;
        check("stream count", 32'(ridx), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
